pipe_ctrl: RTL
==============

# pipe_ctrl

Parametrised pipeline control unit for the in-order RISC-V core. It replaces the single global ok-to-proceed AND with per-stage elastic advance, so a stalled stage blocks only the stages behind it and bubbles ahead of it drain. It also tracks destination registers in flight, generates per-operand forwarding selects for decode, inserts load-use bubbles, and squashes younger stages on a resolved jump. It sits beside the stage modules in the datapath and drives their pipeline-register enables.

## Interface
Parameters:
- NSTAGE, 5, number of stages; stage 0 = fetch output, stage 1 = decode, NSTAGE-1 = writeback; legal ≥4
- REGW, 5, register index width
- LOAD_STAGE, 3, stage whose completion makes load data available; legal 2..NSTAGE-2
- FLUSH_STAGE, 3, stage that resolves jumps; legal 2..NSTAGE-1
- CNTW, 64, retire counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_valid  in  1  stage 0 holds an instruction
- stage_busy  in  NSTAGE  stage i unit not finished this cycle
- dec_rs1, dec_rs2  in  REGW  decode source indices
- dec_use_rs1, dec_use_rs2  in  1  operand actually read
- dec_rd  in  REGW  decode destination
- dec_rd_we  in  1  decode instruction writes rd
- dec_is_load  in  1  decode instruction is a load
- flush  in  1  jump taken by instruction in FLUSH_STAGE
- stage_valid  out  NSTAGE  registered valid per stage (bit 0 mirrors fetch_valid)
- stage_adv  out  NSTAGE  stage i hands its instruction to i+1 (last: retires) this cycle
- fetch_ready  out  1  equals stage_adv[0]
- fwd_sel1, fwd_sel2  out  $clog2(NSTAGE)  0 = register file, j = result of stage j
- load_use_stall  out  1  decode held for load-use
- retire_cnt  out  CNTW  instructions retired since reset

## Operation
- State: valid[1..NSTAGE-1]; for stages 2..NSTAGE-1 a record {rd, we, is_load}; retire_cnt.
- Advance, last stage L: adv[L] = valid[L] & ~busy[L].
- Advance, i<L: adv[i] = valid[i] & ~busy[i] & (~valid[i+1] | adv[i+1]); additionally adv[1] &= ~load_use_stall.
- Next valid[i+1] = adv[i] ? 1 : (adv[i+1] ? 0 : valid[i+1]). Records shift with adv; decode inputs load stage 2 record when adv[1].
- Flush: honoured only in a cycle where adv[FLUSH_STAGE]=1; then valid[1..FLUSH_STAGE] all clear next cycle unless refilled by nothing (adv[0..FLUSH_STAGE-1] forced 0). The flushing instruction itself moves to FLUSH_STAGE+1 normally. Flush held by source until honoured.
- Forward match per operand: candidates j in 2..L with valid[j], we, rd==rs, rs≠0, use=1; select smallest j (youngest). No match → 0.
- Load-use: matched j holds is_load and j < LOAD_STAGE → load_use_stall=1, fwd_sel forced 0. Only when valid[1] and no honoured flush.
- retire_cnt increments by 1 on adv[L], wraps at 2^CNTW.

## Timing
- Reset: valid, records, retire_cnt = 0; hence stage_valid[L:1]=0, stage_adv=0 except bit 0 per input rule, fwd_sel=0, load_use_stall=0.
- stage_adv, fetch_ready, fwd_sel, load_use_stall combinational from registered state and current inputs; state updates at posedge clk.
- Latency: one cycle per stage when no busy; first instruction retires L cycles after its adv[0].
- Simultaneous flush + load-use: flush wins, stall output 0.
- Busy at stage k with full pipe: stages 0..k hold, stages >k drain to empty.
- Reset mid-operation: all in-flight instructions dropped immediately, counter cleared.

## Structure
- Shared package: pipe_rec_t {rd, we, is_load}, fwd-select typedef, legal-range constants.
- Sub-module pipe_hazard_match: combinational youngest-match finder returning sel and is_load hit; instantiated once per operand.

## Test plan
- Reset, fetch_valid=1 constant, busy=0 → stage_valid[4] first high 4 cycles after first adv[0]; retire_cnt then +1 per cycle.
- add x5; sub x6,x5,x1; or x7,x5,x0 back-to-back → sub sees fwd_sel1=2, or sees fwd_sel1=3; rd=x0 producer never selected.
- ld x7; add x8,x7,x7 → load_use_stall=1 exactly one cycle, bubble in stage 2, then fwd_sel1=fwd_sel2=3.
- Full pipe, flush while stage 3 advances → stage_valid[3:1]=0 next cycle; those two younger instructions never counted in retire_cnt.
- Full pipe, busy[3]=1 for 3 cycles → stages 0..3 frozen, stage_valid[4]=0 after one cycle, normal flow resumes cycle after busy drops.
- Assert rst mid-stream → stage_valid[4:1]=0 and retire_cnt=0 without waiting for clk.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and limits for the pipeline control unit and its hazard matcher.
package pipe_ctrl_pkg;

    localparam int unsigned MinStages = 4;
    localparam int unsigned MaxStages = 16;
    localparam int unsigned MaxRegW   = 8;
    localparam int unsigned MaxSelW   = $clog2(MaxStages);

    typedef logic [MaxSelW-1:0] fwd_sel_t;

    // Destination bookkeeping carried alongside each in-flight instruction.
    typedef struct packed {
        logic [MaxRegW-1:0] rd;
        logic               we;
        logic               is_load;
    } pipe_rec_t;

    function automatic pipe_rec_t mk_rec(input logic [MaxRegW-1:0] rd,
                                         input logic               we,
                                         input logic               is_load);
        pipe_rec_t r;
        r.rd      = rd;
        r.we      = we;
        r.is_load = is_load;
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// Youngest-producer finder for one decode source operand.
module pipe_hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned REGW   = 5,
    parameter int unsigned SelW   = $clog2(NSTAGE)
) (
    input  logic      [NSTAGE-1:2] valid_i,
    input  pipe_rec_t [NSTAGE-1:2] rec_i,
    input  logic      [REGW-1:0]   rs_i,
    input  logic                   use_i,
    output logic      [SelW-1:0]   sel_o,
    output logic                   load_hit_o
);

    // Walk oldest to youngest so the last hit written is the youngest producer.
    always_comb begin
        sel_o      = '0;
        load_hit_o = 1'b0;
        for (int j = int'(NSTAGE) - 1; j >= 2; j--) begin
            if (valid_i[j] && rec_i[j].we && use_i && (rs_i != '0) &&
                (rec_i[j].rd == MaxRegW'(rs_i))) begin
                sel_o      = SelW'(j);
                load_hit_o = rec_i[j].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Elastic per-stage pipeline control: advance enables, forwarding selects,
// load-use interlock, jump squash and retire counting.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE      = 5,
    parameter int unsigned REGW        = 5,
    parameter int unsigned LOAD_STAGE  = 3,
    parameter int unsigned FLUSH_STAGE = 3,
    parameter int unsigned CNTW        = 64,
    localparam int unsigned SelW       = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid_i,
    input  logic [NSTAGE-1:0] stage_busy_i,
    input  logic [REGW-1:0]   dec_rs1_i,
    input  logic [REGW-1:0]   dec_rs2_i,
    input  logic              dec_use_rs1_i,
    input  logic              dec_use_rs2_i,
    input  logic [REGW-1:0]   dec_rd_i,
    input  logic              dec_rd_we_i,
    input  logic              dec_is_load_i,
    input  logic              flush_i,
    output logic [NSTAGE-1:0] stage_valid_o,
    output logic [NSTAGE-1:0] stage_adv_o,
    output logic              fetch_ready_o,
    output logic [SelW-1:0]   fwd_sel1_o,
    output logic [SelW-1:0]   fwd_sel2_o,
    output logic              load_use_stall_o,
    output logic [CNTW-1:0]   retire_cnt_o
);

    localparam int LastI  = int'(NSTAGE) - 1;
    localparam int FlushI = int'(FLUSH_STAGE);

    if (NSTAGE < MinStages || NSTAGE > MaxStages || REGW > MaxRegW ||
        LOAD_STAGE < 2 || LOAD_STAGE > NSTAGE - 2 ||
        FLUSH_STAGE < 2 || FLUSH_STAGE > NSTAGE - 1) begin : g_bad_param
        $error("pipe_ctrl: illegal parameter combination");
    end

    logic      [NSTAGE-1:1] valid_q, valid_d;
    pipe_rec_t [NSTAGE-1:2] rec_q, rec_d;
    logic      [CNTW-1:0]   retire_cnt_q, retire_cnt_d;

    logic [NSTAGE-1:0] valid_all;
    logic [NSTAGE-1:0] adv;
    logic [SelW-1:0]   sel1, sel2;
    logic              load_hit1, load_hit2;
    logic              load_use_raw;
    logic              flush_hon;
    logic              load_use_stall;

    assign valid_all = {valid_q, fetch_valid_i};

    pipe_hazard_match #(
        .NSTAGE (NSTAGE),
        .REGW   (REGW),
        .SelW   (SelW)
    ) u_match_rs1 (
        .valid_i    (valid_q[NSTAGE-1:2]),
        .rec_i      (rec_q),
        .rs_i       (dec_rs1_i),
        .use_i      (dec_use_rs1_i),
        .sel_o      (sel1),
        .load_hit_o (load_hit1)
    );

    pipe_hazard_match #(
        .NSTAGE (NSTAGE),
        .REGW   (REGW),
        .SelW   (SelW)
    ) u_match_rs2 (
        .valid_i    (valid_q[NSTAGE-1:2]),
        .rec_i      (rec_q),
        .rs_i       (dec_rs2_i),
        .use_i      (dec_use_rs2_i),
        .sel_o      (sel2),
        .load_hit_o (load_hit2)
    );

    // A load matched before it has completed LOAD_STAGE has no data to forward yet.
    assign load_use_raw = (load_hit1 && (32'(sel1) < LOAD_STAGE)) ||
                          (load_hit2 && (32'(sel2) < LOAD_STAGE));

    // Advance resolves from writeback backwards; the flush decision is final
    // once FLUSH_STAGE is evaluated, before any stage it squashes.
    always_comb begin
        adv            = '0;
        flush_hon      = 1'b0;
        load_use_stall = 1'b0;
        adv[LastI]     = valid_all[LastI] & ~stage_busy_i[LastI];
        for (int i = LastI - 1; i >= 0; i--) begin
            if (i < FlushI) begin
                flush_hon = flush_i & adv[FLUSH_STAGE];
            end
            adv[i] = valid_all[i] & ~stage_busy_i[i] & (~valid_all[i+1] | adv[i+1]);
            if (i == 1) begin
                load_use_stall = valid_q[1] & load_use_raw & ~flush_hon;
                adv[i]         = adv[i] & ~load_use_stall;
            end
            if (i < FlushI && flush_hon) begin
                adv[i] = 1'b0;
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        rec_d        = rec_q;
        retire_cnt_d = retire_cnt_q;
        for (int i = 1; i <= LastI; i++) begin
            if (adv[i-1]) begin
                valid_d[i] = 1'b1;
            end else if (adv[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (flush_hon) begin
            for (int i = 1; i <= FlushI; i++) begin
                valid_d[i] = 1'b0;
            end
        end
        if (adv[1]) begin
            rec_d[2] = mk_rec(MaxRegW'(dec_rd_i), dec_rd_we_i, dec_is_load_i);
        end
        for (int i = 3; i <= LastI; i++) begin
            if (adv[i-1]) begin
                rec_d[i] = rec_q[i-1];
            end
        end
        if (adv[LastI]) begin
            retire_cnt_d = retire_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            rec_q        <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            rec_q        <= rec_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stage_valid_o    = valid_all;
    assign stage_adv_o      = adv;
    assign fetch_ready_o    = adv[0];
    assign fwd_sel1_o       = load_use_stall ? '0 : sel1;
    assign fwd_sel2_o       = load_use_stall ? '0 : sel2;
    assign load_use_stall_o = load_use_stall;
    assign retire_cnt_o     = retire_cnt_q;

endmodule
